stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
Produces the 16-bit binary `value` consumed by the four-digit seven-segment display stage, plus the `sel_clk` digit-refresh clock that display stage needs.
- Counts at a prescaled rate, 0..MAX_VALUE, with wrap-around.
- Controlled by two raw push buttons (start/pause, clear) and a direction switch.
- Sits between board I/O and the display stage.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz; prescale length is CLK_HZ/TICK_HZ cycles (integer, at least 2).
- MAX_VALUE, 9999, highest count; must be at most 9999 so four BCD digits suffice.
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button level change.
- SEL_DIV, 3000, `sel_clk` half-period in clk cycles.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_start_n  input  1  raw start/pause button, active low, asynchronous to clk.
- btn_clear_n  input  1  raw clear button, active low, asynchronous to clk.
- count_down  input  1  direction switch (1 = decrement), asynchronous to clk.
- value  output  16  current count, binary, always ≤ MAX_VALUE.
- running  output  1  high while in RUN.
- sel_clk  output  1  square-wave digit-select clock for the display stage.

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous and active-low. While `rst_n`=0, all outputs and state are held at reset values; logic leaves reset on the first clk edge after deassertion.
- Reset values:
  - value=0, running=0, sel_clk=0, state=IDLE, prescaler=0, sel divider=0.
  - Debounced buttons = released; synchronizers = released / count_down=0.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: the debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press event is a 1-cycle pulse on a released→pressed transition of the debounced level. A release generates no event.
  - `count_down` gets a 2-flop synchronizer only (no debounce).
- FSM states:
  - IDLE: value=0, stopped.
  - RUN: counting.
  - PAUSE: stopped, value held.
- Transitions:
  - Clear press in any state → IDLE: value=0, prescaler=0, effective on the next edge.
  - Start press: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - Clear and start pressed in the same cycle: clear wins, next state is IDLE.
  - `running` is 1 exactly while state=RUN; it is registered and updates on the same edge as the state.
- Prescaler:
  - Increments only in RUN; counts 0..CLK_HZ/TICK_HZ-1, then wraps to 0.
  - A tick is the cycle where prescaler = terminal count.
  - Held (not cleared) in PAUSE, so resuming continues the partial period. Cleared in IDLE.
- Counting, on a tick in RUN (value updates on that edge):
  - count_down=0: value+1, and MAX_VALUE→0.
  - count_down=1: value-1, and 0→MAX_VALUE.
  - Direction is the synchronized switch level in the tick cycle.
  - A start press coinciding with a tick: the tick is applied and state goes to PAUSE.
- First tick from IDLE occurs exactly CLK_HZ/TICK_HZ cycles after entering RUN.
- sel_clk:
  - Free-running in all states, independent of the FSM.
  - Toggles every SEL_DIV cycles, giving a period of 2·SEL_DIV cycles.
  - Registered output, glitch-free.
- Reset mid-operation: immediate return to reset values. Any debounce in progress is discarded.

Decomposition:
- Shared package (`stopwatch_pkg`):
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - Value width constant 16.
- Sub-module `button_conditioner`:
  - Parameter: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, btn_n → pressed level, press pulse.
  - Instantiated twice.
- Prescaler, counter, FSM and sel_clk divider stay in the top module.

Test Plan:
Bench parameters: CLK_HZ=100, TICK_HZ=10 (prescale 10), DEBOUNCE_CYCLES=4, SEL_DIV=3, MAX_VALUE=9999.
1. Reset and sel_clk: assert rst_n=0 mid-run → value=0, running=0, sel_clk=0 immediately. After release, sel_clk toggles every 3 cycles (period 6).
2. Debounce and start: btn_start_n pulsed low for 2 cycles → no state change. Held low 6 cycles → one press, running=1. First value=1 exactly 10 cycles after RUN entry; value=5 after 50 cycles.
3. Pause and resume: pause after 5 ticks plus 3 prescale cycles → value holds 5. Resume → value=6 after 7 more cycles.
4. Wrap-around:
   - Count up from value 9999 → next tick gives 0.
   - count_down=1 from IDLE, start → first tick gives 9999, then 9998.
5. Clear priority: start and clear presses debounced in the same cycle while in RUN with value 42 → state IDLE, value=0, running=0. The next start gives first tick after a full 10 cycles.
6. Tick collision: start press coincides with a tick at value 7 → value=8, state PAUSE, running=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter: FSM encoding, value width
// and the wrap-around step used on every tick.
package stopwatch_pkg;

   localparam int VALUE_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   // One count step in either direction, wrapping between 0 and max_value.
   function automatic logic [VALUE_W-1:0] next_value(
      input logic [VALUE_W-1:0] cur,
      input logic               down,
      input logic [VALUE_W-1:0] max_value
   );
      logic [VALUE_W-1:0] res;
      if (down) begin
         res = (cur == '0) ? max_value : cur - VALUE_W'(1);
      end else begin
         res = (cur == max_value) ? '0 : cur + VALUE_W'(1);
      end
      return res;
   endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Board-side signal bundle of the stopwatch: raw controls in, count,
// run flag and display refresh clock out.
interface stopwatch_counter_if;
   import stopwatch_pkg::*;

   logic               btn_start_n;
   logic               btn_clear_n;
   logic               count_down;
   logic [VALUE_W-1:0] value;
   logic               running;
   logic               sel_clk;

   modport master (
      output btn_start_n, btn_clear_n, count_down,
      input  value, running, sel_clk
   );

   modport slave (
      input  btn_start_n, btn_clear_n, count_down,
      output value, running, sel_clk
   );

endinterface

// File: rtl/button_conditioner.sv
// Raw active-low push button -> synchronized, debounced pressed level plus a
// single-cycle pulse on each accepted press.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic pressed,
   output logic press
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             raw_pressed;

   assign raw_pressed = ~sync2_q;

   // Any cycle where the input agrees with the accepted level restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (raw_pressed != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = raw_pressed;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign pressed = level_q;
   assign press   = press_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: start/pause/clear FSM, tick prescaler, wrapping up/down
// counter and a free-running digit-select clock for the display stage.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ          = 12000000,
   parameter int TICK_HZ         = 100,
   parameter int MAX_VALUE       = 9999,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int SEL_DIV         = 3000
) (
   input  logic                clk,
   input  logic                rst_n,
   stopwatch_counter_if.slave  io
);

   localparam int                 PRESCALE = CLK_HZ / TICK_HZ;
   localparam int                 PS_W     = $clog2(PRESCALE);
   localparam logic [PS_W-1:0]    PS_LAST  = PS_W'(PRESCALE - 1);
   localparam int                 SEL_W    = $clog2(SEL_DIV + 1);
   localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(SEL_DIV - 1);
   localparam logic [VALUE_W-1:0] MAX_V    = VALUE_W'(MAX_VALUE);

   logic start_level, start_press;
   logic clear_level, clear_press;
   logic unused_levels;

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (io.btn_start_n),
      .pressed (start_level),
      .press   (start_press)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_n   (io.btn_clear_n),
      .pressed (clear_level),
      .press   (clear_press)
   );

   assign unused_levels = start_level ^ clear_level;

   logic               dir_sync1_q, dir_sync2_q;
   sw_state_e          state_q, state_d;
   logic               running_q, running_d;
   logic [PS_W-1:0]    prescaler_q, prescaler_d;
   logic [VALUE_W-1:0] value_q, value_d;
   logic [SEL_W-1:0]   sel_cnt_q, sel_cnt_d;
   logic               sel_clk_q, sel_clk_d;
   logic               tick;

   assign tick = (state_q == RUN) && (prescaler_q == PS_LAST);

   // Clear outranks start; a start press on a tick still applies that tick.
   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      prescaler_d = prescaler_q;
      if (clear_press) begin
         state_d     = IDLE;
         value_d     = '0;
         prescaler_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               value_d     = '0;
               prescaler_d = '0;
               if (start_press) state_d = RUN;
            end
            RUN: begin
               prescaler_d = tick ? '0 : prescaler_q + PS_W'(1);
               if (tick) value_d = next_value(value_q, dir_sync2_q, MAX_V);
               if (start_press) state_d = PAUSE;
            end
            PAUSE: begin
               if (start_press) state_d = RUN;
            end
            default: begin
               state_d     = IDLE;
               value_d     = '0;
               prescaler_d = '0;
            end
         endcase
      end
      running_d = (state_d == RUN);

      sel_cnt_d = sel_cnt_q + SEL_W'(1);
      sel_clk_d = sel_clk_q;
      if (sel_cnt_q == SEL_LAST) begin
         sel_cnt_d = '0;
         sel_clk_d = ~sel_clk_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_sync1_q <= 1'b0;
         dir_sync2_q <= 1'b0;
         state_q     <= IDLE;
         running_q   <= 1'b0;
         prescaler_q <= '0;
         value_q     <= '0;
         sel_cnt_q   <= '0;
         sel_clk_q   <= 1'b0;
      end else begin
         dir_sync1_q <= io.count_down;
         dir_sync2_q <= dir_sync1_q;
         state_q     <= state_d;
         running_q   <= running_d;
         prescaler_q <= prescaler_d;
         value_q     <= value_d;
         sel_cnt_q   <= sel_cnt_d;
         sel_clk_q   <= sel_clk_d;
      end
   end

   assign io.value   = value_q;
   assign io.running = running_q;
   assign io.sel_clk = sel_clk_q;

endmodule
